// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed scan controller for the shared 7-segment FND decoder.
// Scans N_DIG digits with dead time between them; new values swap in only at frame boundaries.
module fnd_scan_ctrl #(
  parameter int N_DIG    = 4,
  parameter int ON_CYC   = 50000,
  parameter int DEAD_CYC = 500
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [4*N_DIG-1:0] i_data,
  input  logic               i_lzb,
  output logic [3:0]         o_nib,
  output logic [N_DIG-1:0]   o_com,
  output logic               o_frame
);

  localparam int MAXC = (ON_CYC > DEAD_CYC) ? ON_CYC : DEAD_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(N_DIG);

  localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIG - 1);

  typedef enum logic {
    ST_DEAD = 1'b0,
    ST_ON   = 1'b1
  } st_t;

  st_t                st_q, st_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [4*N_DIG-1:0] disp_q, disp_d;
  logic [4*N_DIG-1:0] pend_q, pend_d;
  logic               pend_v_q, pend_v_d;
  logic               frame_q, frame_d;
  logic               boundary;
  logic [N_DIG-1:0]   blank;
  logic               zero_above;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st_q     <= ST_DEAD;
      cnt_q    <= '0;
      idx_q    <= '0;
      disp_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      frame_q  <= frame_d;
    end
  end

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q + CW'(1);
    idx_d    = idx_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    boundary = 1'b0;

    case (st_q)
      ST_DEAD: begin
        if (cnt_q == DEAD_LAST) begin
          st_d  = ST_ON;
          cnt_d = '0;
        end
      end
      ST_ON: begin
        if (cnt_q == ON_LAST) begin
          st_d  = ST_DEAD;
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d    = '0;
            boundary = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        st_d  = ST_DEAD;
        cnt_d = '0;
      end
    endcase

    // A load landing on the boundary itself bypasses the pending register.
    if (boundary) begin
      if (i_load) begin
        disp_d   = i_data;
        pend_v_d = 1'b0;
      end else if (pend_v_q) begin
        disp_d   = pend_q;
        pend_v_d = 1'b0;
      end
    end else if (i_load) begin
      pend_d   = i_data;
      pend_v_d = 1'b1;
    end

    frame_d = boundary;
  end

  always_comb begin
    zero_above = 1'b1;
    blank      = '0;
    for (int k = N_DIG - 1; k >= 1; k--) begin
      zero_above = zero_above && (disp_q[4*k +: 4] == 4'h0);
      blank[k]   = i_lzb && zero_above;
    end
  end

  always_comb begin
    o_nib = disp_q[4*idx_q +: 4];
    o_com = '1;
    if (st_q == ST_ON && !blank[idx_q]) begin
      o_com = ~(N_DIG'(1) << idx_q);
    end
  end

  assign o_frame = frame_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl with N_DIG=4, ON_CYC=4, DEAD_CYC=2 (24-cycle frame).
// Stimulus pushes the expected outputs of every cycle; a negedge monitor pops and compares.
module tb_fnd_scan_ctrl;

  logic        i_clk;
  logic        i_rst;
  logic        i_load;
  logic [15:0] i_data;
  logic        i_lzb;
  logic [3:0]  o_nib;
  logic [3:0]  o_com;
  logic        o_frame;

  typedef struct {
    logic [3:0] com;
    logic [3:0] nib;
    logic       frame;
    int         tag;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   tag_ctr     = 0;

  fnd_scan_ctrl #(
    .N_DIG   (4),
    .ON_CYC  (4),
    .DEAD_CYC(2)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (i_load),
    .i_data (i_data),
    .i_lzb  (i_lzb),
    .o_nib  (o_nib),
    .o_com  (o_com),
    .o_frame(o_frame)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Expected outputs at position pos (0..23) of a frame showing value d.
  function automatic void model(input int pos, input logic [15:0] d, input logic lzb,
                                input bit first, output logic [3:0] com,
                                output logic [3:0] nib, output logic fr);
    int          slot;
    int          w;
    logic [3:0]  one;
    logic [15:0] upper;
    slot  = pos / 6;
    w     = pos % 6;
    one   = 4'b0001;
    upper = d >> (slot * 4);
    nib   = d[slot*4 +: 4];
    com   = 4'hF;
    if (w >= 2 && !(lzb && slot >= 1 && upper == 16'h0000)) com = ~(one << slot);
    fr = (pos == 0) && !first;
  endfunction

  task automatic applyStimulus(input logic rst, input logic load, input logic [15:0] data,
                               input logic lzb, input logic [3:0] ecom,
                               input logic [3:0] enib, input logic eframe);
    exp_t e;
    i_rst   = rst;
    i_load  = load;
    i_data  = data;
    i_lzb   = lzb;
    e.com   = ecom;
    e.nib   = enib;
    e.frame = eframe;
    e.tag   = tag_ctr;
    tag_ctr++;
    sb.push_back(e);
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_frame(input logic [15:0] d, input logic lzb, input bit first,
                           input int npos, input int lp1, input logic [15:0] ld1,
                           input int lp2, input logic [15:0] ld2);
    logic [3:0]  com;
    logic [3:0]  nib;
    logic        fr;
    logic        load;
    logic [15:0] data;
    for (int pos = 0; pos < npos; pos++) begin
      model(pos, d, lzb, first, com, nib, fr);
      load = (pos == lp1) || (pos == lp2);
      data = (pos == lp1) ? ld1 : ((pos == lp2) ? ld2 : 16'hDEAD);
      applyStimulus(1'b0, load, data, lzb, com, nib, fr);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    vectors++;
    if (o_com !== e.com || o_nib !== e.nib || o_frame !== e.frame) begin
      miscompares++;
      $display("[TB] FAIL vec%0d: got com=%b nib=%h frame=%b, want com=%b nib=%h frame=%b",
               e.tag, o_com, o_nib, o_frame, e.com, e.nib, e.frame);
    end
  endtask

  always @(negedge i_clk) begin
    if (sb.size() > 0) begin
      checkOutput(sb.pop_front());
    end
  end

  initial begin
    i_rst  = 1'b1;
    i_load = 1'b0;
    i_data = 16'h0000;
    i_lzb  = 1'b0;
    @(posedge i_clk);
    #1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 4'hF, 4'h0, 1'b0);

    $display("[TB] reset release and mid-frame load of 12A7");
    run_frame(16'h0000, 1'b0, 1'b1, 24, 10, 16'h12A7, -1, 16'h0);
    $display("[TB] two loads in one frame");
    run_frame(16'h12A7, 1'b0, 1'b0, 24, 3, 16'h1111, 15, 16'h2222);
    $display("[TB] load on boundary overrides pending 9999");
    run_frame(16'h2222, 1'b0, 1'b0, 24, 5, 16'h9999, 23, 16'h0005);
    run_frame(16'h0005, 1'b0, 1'b0, 24, 8, 16'h0040, -1, 16'h0);
    $display("[TB] leading-zero blanking");
    run_frame(16'h0040, 1'b1, 1'b0, 24, 4, 16'h0000, -1, 16'h0);
    run_frame(16'h0000, 1'b1, 1'b0, 24, 2, 16'h0300, -1, 16'h0);
    $display("[TB] reset during ON slot of digit 2");
    run_frame(16'h0300, 1'b0, 1'b0, 14, 3, 16'h5555, -1, 16'h0);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 4'hF, 4'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 4'hF, 4'h0, 1'b0);
    run_frame(16'h0000, 1'b0, 1'b1, 24, -1, 16'h0, -1, 16'h0);
    run_frame(16'h0000, 1'b0, 1'b0, 24, -1, 16'h0, -1, 16'h0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge i_clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expected vectors left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
